// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU instruction path.
// Contents: opcode encodings, instruction field positions, issue FSM state
// encoding and small helpers that decode an instruction word.
package tpu_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // Instruction word layout: [15:14] opcode, [13] mem sel, [11:10] row,
    // [9:8] col, [7:0] imm.
    localparam int INSTR_W  = 16;
    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 14;
    localparam int MSEL_BIT = 13;
    localparam int ROW_HI   = 11;
    localparam int ROW_LO   = 10;
    localparam int COL_HI   = 9;
    localparam int COL_LO   = 8;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_RUN    = 2'b10
    } issue_state_e;

    // Opcode field of an instruction word.
    function automatic logic [1:0] get_opcode(input logic [INSTR_W-1:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction

    // Hold length of a RUN: imm[3:0], or the default when that nibble is zero.
    function automatic logic [3:0] run_len(input logic [INSTR_W-1:0] w,
                                           input logic [3:0]         dflt);
        return (w[IMM_LO+3:IMM_LO] == 4'd0) ? dflt : w[IMM_LO+3:IMM_LO];
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Registered instruction FIFO (no bypass): an entry pushed at one edge is
// visible on head_data and poppable from the following edge.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of both pointers (wins over push/pop)
//   push, push_data write one entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head_data       oldest entry
//   full, empty     occupancy flags derived from the pointers
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;
    assign head_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush returns both pointers to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array, cleared on reset so no stale word can ever reach the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer feeding the TPU control unit.
// Assembles 16-bit instructions from a high-byte-first byte stream, queues
// them in instr_fifo and issues them one at a time on `instruction`. A RUN is
// held for its programmed cycle count; every other opcode lasts one cycle.
// When nothing is issuing the output is NOP (16'h0000).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous clear of FIFO, byte phase and issue
//   byte_in/valid/ready     byte-stream handshake (accept on valid && ready)
//   instruction             registered instruction word to the control unit
//   issue_valid, run_active current issue is FIFO-sourced / is a RUN
//   fifo_full, fifo_empty   FIFO occupancy flags
//   busy                    anything pending or issuing
module instr_sequencer
    import tpu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RUN_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] instruction,
    output logic        issue_valid,
    output logic        run_active,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        busy
);

    localparam logic [3:0] RUN_DFLT = RUN_CYCLES[3:0];

    logic         r_phase;
    logic [7:0]   r_hi;
    issue_state_e r_state;
    issue_state_e w_state_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;
    logic [15:0]  r_instr;
    logic [15:0]  w_instr_nxt;
    logic         r_issue_valid;
    logic         r_run_active;
    logic         w_done;
    logic         w_pop;
    logic         w_push;
    logic         w_accept;
    logic         w_full;
    logic         w_empty;
    logic [15:0]  w_head;

    // Ready depends on registered state only, so a pop in this cycle cannot
    // open the handshake until the next one.
    assign byte_ready  = !(r_phase && w_full);
    assign w_accept    = byte_valid && byte_ready;
    assign w_push      = w_accept && r_phase && !flush;

    assign instruction = r_instr;
    assign issue_valid = r_issue_valid;
    assign run_active  = r_run_active;
    assign fifo_full   = w_full;
    assign fifo_empty  = w_empty;
    assign busy        = r_phase || !w_empty || (r_state != ST_IDLE);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_push),
        .push_data ({r_hi, byte_in}),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Byte assembler: first accepted byte is staged as the high half,
    // the second completes the word and is pushed in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_hi    <= 8'h00;
        end else if (flush) begin
            r_phase <= 1'b0;
            r_hi    <= 8'h00;
        end else if (w_accept) begin
            if (!r_phase) begin
                r_hi    <= byte_in;
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
            end
        end else begin
            r_phase <= r_phase;
        end
    end

    // Issue FSM next state: the last cycle of an issue (or idle) pops the next
    // entry directly so consecutive instructions run without a NOP gap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_instr_nxt = r_instr;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE:   w_done = 1'b1;
            ST_SINGLE: w_done = 1'b1;
            ST_RUN:    w_done = (r_cnt <= 4'd1);
            default:   w_done = 1'b1;
        endcase

        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
            w_instr_nxt = 16'h0000;
        end else if (w_done) begin
            if (!w_empty) begin
                w_pop       = 1'b1;
                w_instr_nxt = w_head;
                if (get_opcode(w_head) == OP_RUN) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = run_len(w_head, RUN_DFLT);
                end else begin
                    w_state_nxt = ST_SINGLE;
                    w_cnt_nxt   = 4'd0;
                end
            end else begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
                w_instr_nxt = 16'h0000;
            end
        end else begin
            w_cnt_nxt = r_cnt - 4'd1;
        end
    end

    // Issue FSM state and registered issue outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_instr       <= 16'h0000;
            r_issue_valid <= 1'b0;
            r_run_active  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_instr       <= w_instr_nxt;
            r_issue_valid <= (w_state_nxt != ST_IDLE);
            r_run_active  <= (w_state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction;
    logic        issue_valid;
    logic        run_active;
    logic        fifo_full;
    logic        fifo_empty;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model: queue of assembled words plus the word being issued
    // and how many cycles of it remain.
    logic [15:0] mq[$];
    bit          m_half;
    logic [7:0]  m_hi;
    logic [15:0] m_cur;
    int          m_rem;

    instr_sequencer #(.DEPTH(DEPTH), .RUN_CYCLES(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .instruction (instruction),
        .issue_valid (issue_valid),
        .run_active  (run_active),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model step for one clock edge (or reset), using pre-edge values.
    task automatic model_step();
        int sz;
        bit acc;
        logic [15:0] w;
        if (!rst_n || flush) begin
            mq.delete();
            m_half = 0;
            m_cur  = 16'h0000;
            m_rem  = 0;
            if (!rst_n) m_hi = 8'h00;
            return;
        end
        sz  = mq.size();
        acc = byte_valid && !(m_half && sz == DEPTH);
        if (m_rem <= 1 && sz > 0) begin
            w = mq.pop_front();
            m_cur = w;
            if (w[15:14] == 2'b01) m_rem = (w[3:0] == 4'd0) ? 10 : int'(w[3:0]);
            else                   m_rem = 1;
        end else if (m_rem > 1) begin
            m_rem = m_rem - 1;
        end else begin
            m_rem = 0;
            m_cur = 16'h0000;
        end
        if (acc) begin
            if (m_half) begin
                mq.push_back({m_hi, byte_in});
                m_half = 0;
            end else begin
                m_hi   = byte_in;
                m_half = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_eq("instruction", instruction, m_cur);
                check_eq("issue_valid", issue_valid, m_rem > 0);
                check_eq("run_active", run_active, (m_rem > 0) && (m_cur[15:14] == 2'b01));
                check_eq("fifo_full", fifo_full, mq.size() == DEPTH);
                check_eq("fifo_empty", fifo_empty, mq.size() == 0);
                check_eq("busy", busy, m_half || (mq.size() > 0) || (m_rem > 0));
                check_eq("byte_ready", byte_ready, !(m_half && mq.size() == DEPTH));
            end
        end
    end

    // Present one byte and hold it until accepted; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("byte_accept_wait", n < 100, 1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("idle_wait", n < 300, 1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int run_cnt;
        rst_n = 1'b0; flush = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        tick(3);
        check_eq("rst_instruction", instruction, 16'h0000);
        check_eq("rst_byte_ready", byte_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fifo_empty", fifo_empty, 1);
        check_eq("rst_issue_valid", issue_valid, 0);
        rst_n = 1'b1;
        chk_en = 1;

        // LOAD: one-cycle issue, visible the edge after the word is pushed.
        send_byte(8'h81);
        send_byte(8'h2A);
        check_eq("load_before_pop", instruction, 16'h0000);
        tick(1);
        check_eq("load_instr", instruction, 16'h812A);
        check_eq("load_valid", issue_valid, 1);
        tick(1);
        check_eq("load_after", instruction, 16'h0000);
        check_eq("load_valid_after", issue_valid, 0);

        // RUN with default length.
        send_byte(8'h40);
        send_byte(8'h00);
        run_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (instruction == 16'h4000 && run_active) run_cnt++;
        end
        check_eq("run_default_len", run_cnt, 10);

        // Back-to-back RUN then STORE.
        send_byte(8'h40); send_byte(8'h03); send_byte(8'hC5); send_byte(8'h00);
        wait_idle();

        // Fill the FIFO behind a long RUN, then stage a high byte.
        send_byte(8'h40); send_byte(8'h0F);
        send_byte(8'h81); send_byte(8'h01);
        send_byte(8'h42); send_byte(8'h02);
        send_byte(8'hC3); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h85);
        check_eq("full_flag", fifo_full, 1);
        check_eq("full_ready_low", byte_ready, 0);
        send_byte(8'h05);
        wait_idle();

        // flush at cycle 4 of a default RUN.
        send_byte(8'h40); send_byte(8'h00);
        tick(4);
        check_eq("pre_flush_run", run_active, 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check_eq("flush_instr", instruction, 16'h0000);
        check_eq("flush_empty", fifo_empty, 1);
        check_eq("flush_busy", busy, 0);

        // Same scenario aborted by a reset pulse.
        send_byte(8'h40); send_byte(8'h00);
        tick(4);
        rst_n = 1'b0;
        #1;
        check_eq("rstp_instr", instruction, 16'h0000);
        check_eq("rstp_empty", fifo_empty, 1);
        check_eq("rstp_busy", busy, 0);
        rst_n = 1'b1;
        tick(1);

        // Randomized traffic with occasional flush and reset pulses.
        for (int i = 0; i < 1500; i++) begin
            byte_valid = ($urandom_range(0, 2) != 0);
            byte_in    = 8'($urandom);
            flush      = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        flush = 1'b0;
        wait_idle();
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
